// File: rtl/spi_nor_shifter.sv
// SPI mode-0 byte shifter for the NOR-flash controller: one byte per valid/ready handshake,
// MSB first, chip select held low across a multi-byte command until tx_last or abort.
module spi_nor_shifter #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       p_clk,
    input  logic       p_reset_n,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       abort,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       s_clk,
    output logic       s_css,
    output logic       s_mosi,
    input  logic       s_miso
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        GAP   = 3'd3,
        CSH   = 3'd4
    } state_t;

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    state_t     state_r, state_s;
    logic [7:0] cnt_r, cnt_s;
    logic [3:0] edge_r, edge_s;
    logic [7:0] tx_sh_r, tx_sh_s;
    logic       last_r, last_s;
    logic [7:0] rx_sh_r, rx_sh_s;
    logic [7:0] rx_data_r, rx_data_s;
    logic       rx_valid_r, rx_valid_s;
    logic       sclk_r, sclk_s;
    logic       css_r, css_s;
    logic       mosi_r, mosi_s;
    logic       accept_s;
    logic       abort_s;

    assign tx_ready = (state_r == IDLE) || (state_r == GAP);
    assign busy     = (state_r != IDLE);
    assign accept_s = tx_valid && tx_ready;
    assign abort_s  = abort && (state_r != IDLE);

    assign rx_valid = rx_valid_r;
    assign rx_data  = rx_data_r;
    assign s_clk    = sclk_r;
    assign s_css    = css_r;
    assign s_mosi   = mosi_r;

    // Next-state and next-output decode; abort overrides everything else, including an accept.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        edge_s     = edge_r;
        tx_sh_s    = tx_sh_r;
        last_s     = last_r;
        rx_sh_s    = rx_sh_r;
        rx_data_s  = rx_data_r;
        rx_valid_s = 1'b0;
        sclk_s     = sclk_r;
        css_s      = css_r;
        mosi_s     = mosi_r;
        if (abort_s) begin
            state_s = CSH;
            cnt_s   = RELOAD;
            css_s   = 1'b1;
            sclk_s  = 1'b0;
            mosi_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE, GAP: begin
                    sclk_s = 1'b0;
                    if (accept_s) begin
                        state_s = SETUP;
                        cnt_s   = RELOAD;
                        edge_s  = 4'd0;
                        tx_sh_s = tx_data;
                        last_s  = tx_last;
                        css_s   = 1'b0;
                        mosi_s  = tx_data[7];
                    end else if (state_r == IDLE) begin
                        css_s = 1'b1;
                    end else begin
                        css_s = 1'b0;
                    end
                end
                SETUP, SHIFT: begin
                    if (cnt_r == 8'd0) begin
                        cnt_s   = RELOAD;
                        sclk_s  = ~sclk_r;
                        edge_s  = 4'(edge_r + 4'd1);
                        state_s = SHIFT;
                        if (!sclk_r) begin
                            // rising edge: capture s_miso
                            rx_sh_s = {rx_sh_r[6:0], s_miso};
                        end else if (edge_r == 4'd15) begin
                            rx_valid_s = 1'b1;
                            rx_data_s  = rx_sh_r;
                            if (last_r) begin
                                state_s = CSH;
                            end else begin
                                state_s = GAP;
                            end
                        end else begin
                            tx_sh_s = {tx_sh_r[6:0], 1'b0};
                            mosi_s  = tx_sh_r[6];
                        end
                    end else begin
                        cnt_s = cnt_r - 8'd1;
                    end
                end
                CSH: begin
                    css_s  = 1'b1;
                    sclk_s = 1'b0;
                    if (cnt_r == 8'd0) begin
                        state_s = IDLE;
                    end else begin
                        cnt_s = cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_s = IDLE;
                    css_s   = 1'b1;
                    sclk_s  = 1'b0;
                    mosi_s  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge p_clk or negedge p_reset_n) begin
        if (!p_reset_n) begin
            state_r    <= IDLE;
            cnt_r      <= 8'd0;
            edge_r     <= 4'd0;
            tx_sh_r    <= 8'd0;
            last_r     <= 1'b0;
            rx_sh_r    <= 8'd0;
            rx_data_r  <= 8'd0;
            rx_valid_r <= 1'b0;
            sclk_r     <= 1'b0;
            css_r      <= 1'b1;
            mosi_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            edge_r     <= edge_s;
            tx_sh_r    <= tx_sh_s;
            last_r     <= last_s;
            rx_sh_r    <= rx_sh_s;
            rx_data_r  <= rx_data_s;
            rx_valid_r <= rx_valid_s;
            sclk_r     <= sclk_s;
            css_r      <= css_s;
            mosi_r     <= mosi_s;
        end
    end

endmodule

// File: tb/tb_spi_nor_shifter.sv
// Randomized scoreboard bench for spi_nor_shifter: a slave model drives s_miso, a monitor
// reassembles s_mosi and checks every rx_valid against the queued expectation.
module tb_spi_nor_shifter;

    localparam int H = 2;

    logic       p_clk = 1'b0;
    logic       p_reset_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_last = 1'b0;
    logic       abort = 1'b0;
    logic       s_miso = 1'b0;
    logic       tx_ready, rx_valid, busy, s_clk, s_css, s_mosi;
    logic [7:0] rx_data;

    spi_nor_shifter #(.CLK_DIV(H)) dut (
        .p_clk(p_clk), .p_reset_n(p_reset_n), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_last(tx_last), .abort(abort), .rx_valid(rx_valid),
        .rx_data(rx_data), .busy(busy), .s_clk(s_clk), .s_css(s_css), .s_mosi(s_mosi),
        .s_miso(s_miso)
    );

    always #5 p_clk = ~p_clk;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        int         c0;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         acc_cnt = 0;
    logic [7:0] cur_miso = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // cycle counter
    initial forever begin
        @(posedge p_clk);
        cyc++;
    end

    // SPI slave: presents bit (7 - rising edges seen) of the current response byte
    initial begin
        int   seen_acc;
        int   rise_cnt;
        logic prev_clk;
        seen_acc = 0;
        rise_cnt = 0;
        prev_clk = 1'b0;
        forever begin
            @(negedge p_clk);
            if (seen_acc != acc_cnt) begin
                seen_acc = acc_cnt;
                rise_cnt = 0;
            end else if (s_clk && !prev_clk) begin
                rise_cnt++;
            end
            prev_clk = s_clk;
            if (rise_cnt < 8) s_miso = cur_miso[3'(7 - rise_cnt)];
            else              s_miso = 1'b0;
        end
    end

    // monitor: sample s_mosi at each s_clk rise, compare on every rx_valid
    initial begin
        int         bits;
        logic [7:0] mosi_acc;
        logic       prev_clk;
        exp_t       e;
        bits = 0;
        mosi_acc = 8'd0;
        prev_clk = 1'b0;
        forever begin
            @(negedge p_clk);
            if (!busy) begin
                bits = 0;
            end else if (s_clk && !prev_clk) begin
                mosi_acc = {mosi_acc[6:0], s_mosi};
                bits++;
            end
            prev_clk = s_clk;
            if (rx_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_rx_valid: actual rx_data %0h with empty queue", rx_data);
                end else begin
                    e = sb.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e.rx));
                    check("mosi_byte", 32'(mosi_acc), 32'(e.tx));
                    check("rx_latency", 32'(cyc - e.c0), 32'(16 * H + 1));
                    check("sclk_rises", 32'(bits), 32'd8);
                end
                bits = 0;
            end
        end
    end

    // present a byte and wait (bounded) for the handshake, leaving tx_valid low afterwards
    task automatic send(input logic [7:0] d, input logic l, input logic [7:0] m);
        int w;
        w = 0;
        @(negedge p_clk);
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = l;
        while (!tx_ready && w < 300) begin
            @(negedge p_clk);
            w++;
        end
        check("accept_timeout", 32'(tx_ready), 32'd1);
        cur_miso = m;
        sb.push_back('{tx: d, rx: m, c0: cyc});
        acc_cnt++;
        @(negedge p_clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx();
        int w;
        w = 0;
        @(negedge p_clk);
        while (!rx_valid && w < 400) begin
            @(negedge p_clk);
            w++;
        end
        check("rx_timeout", 32'(rx_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge p_clk);
        while (busy && w < 400) begin
            @(negedge p_clk);
            w++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // one command of n random bytes with random inter-byte gaps
    task automatic run_cmd(input int n);
        logic [7:0] d, m;
        int         gap;
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            m = 8'($urandom);
            send(d, (i == n - 1), m);
            if (i < n - 1) begin
                wait_rx();
                check("gap_css_clk_first", {s_css, s_clk}, 32'd0);
                gap = $urandom_range(0, 5);
                repeat (gap) begin
                    @(negedge p_clk);
                    check("gap_css_clk", {s_css, s_clk}, 32'd0);
                end
            end
        end
        wait_idle();
    endtask

    initial begin
        int         r;
        logic       prev;
        logic [7:0] d, m, held;
        int         w;

        repeat (3) @(negedge p_clk);
        check("rst_s_css", 32'(s_css), 32'd1);
        check("rst_s_clk", 32'(s_clk), 32'd0);
        check("rst_s_mosi", 32'(s_mosi), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        p_reset_n = 1'b1;

        // single last byte, deselect timing afterwards
        send(8'hA5, 1'b1, 8'h3C);
        wait_rx();
        check("csh_css_rx_cycle", 32'(s_css), 32'd0);
        @(negedge p_clk);
        check("csh_css_1", {s_css, busy}, 32'd3);
        @(negedge p_clk);
        check("csh_css_2", {s_css, busy}, 32'd2);

        // two-byte command with a 5-cycle gap
        send(8'h9F, 1'b0, 8'h5A);
        wait_rx();
        repeat (5) begin
            @(negedge p_clk);
            check("gap5_css_clk", {s_css, s_clk}, 32'd0);
        end
        send(8'h00, 1'b1, 8'hC3);
        wait_idle();

        // tx_valid held high across a 3-byte command
        @(negedge p_clk);
        tx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            m = 8'($urandom);
            tx_data = d;
            tx_last = (i == 2);
            w = 0;
            while (!tx_ready && w < 300) begin
                @(negedge p_clk);
                w++;
            end
            if (i > 0) check("accept_with_rx_valid", 32'(rx_valid), 32'd1);
            cur_miso = m;
            sb.push_back('{tx: d, rx: m, c0: cyc});
            acc_cnt++;
            @(negedge p_clk);
            check("single_accept", 32'(tx_ready), 32'd0);
        end
        tx_valid = 1'b0;
        wait_idle();

        // abort at the third s_clk rise
        held = rx_data;
        send(8'h06, 1'b1, 8'hE7);
        r = 0;
        prev = s_clk;
        w = 0;
        while (r < 3 && w < 200) begin
            @(negedge p_clk);
            if (s_clk && !prev) r++;
            prev = s_clk;
            w++;
        end
        check("abort_rises_seen", 32'(r), 32'd3);
        abort = 1'b1;
        @(negedge p_clk);
        abort = 1'b0;
        void'(sb.pop_back());
        check("abort_pins", {s_css, s_clk, s_mosi, busy}, 32'b1001);
        check("abort_no_rx", 32'(rx_valid), 32'd0);
        @(negedge p_clk);
        check("abort_busy_1", {busy, rx_valid}, 32'b10);
        @(negedge p_clk);
        check("abort_busy_0", {busy, rx_valid}, 32'b00);
        check("abort_rx_data_held", 32'(rx_data), 32'(held));

        // reset in the middle of a byte
        send(8'h3B, 1'b1, 8'h81);
        repeat (10) @(negedge p_clk);
        #2 p_reset_n = 1'b0;
        #1;
        check("midrst_pins", {s_css, s_clk, busy, rx_valid}, 32'b1000);
        void'(sb.pop_back());
        repeat (3) @(negedge p_clk);
        p_reset_n = 1'b1;
        @(negedge p_clk);
        check("midrst_release", {tx_ready, busy}, 32'b10);

        // randomized commands
        for (int k = 0; k < 12; k++) begin
            run_cmd($urandom_range(1, 4));
            repeat ($urandom_range(0, 3)) @(negedge p_clk);
        end

        repeat (3) @(negedge p_clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
